// File: rtl/cam_rgb444_capture_if.sv
// ---------------------------------------------------------------------------
// cam_rgb444_capture_if
//
// Bundles the camera byte stream (vsync/href/d) and the frame-buffer write
// port (pix_data/pix_addr/pix_we) plus the frame status flags of
// cam_rgb444_capture.
//
// Modports:
//   master : camera/driver side -> drives vsync, href, d; observes the
//            frame-buffer write port and status flags.
//   slave  : capture block      -> consumes vsync, href, d; drives the
//            frame-buffer write port and status flags.
//
// Parameter:
//   ADDR_W : width of the frame-buffer write address.
// ---------------------------------------------------------------------------
interface cam_rgb444_capture_if #(
    parameter int ADDR_W = 17
);
    logic              vsync;
    logic              href;
    logic [7:0]        d;
    logic [11:0]       pix_data;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_we;
    logic              frame_done;
    logic              line_err;

    modport master (
        output vsync, href, d,
        input  pix_data, pix_addr, pix_we, frame_done, line_err
    );

    modport slave (
        input  vsync, href, d,
        output pix_data, pix_addr, pix_we, frame_done, line_err
    );
endinterface

// File: rtl/cam_rgb444_capture.sv
// ---------------------------------------------------------------------------
// cam_rgb444_capture
//
// Packs the OV7670 8-bit byte stream into 12-bit RGB444 words and writes them
// to the frame buffer that the VGA output path reads. Everything runs on the
// camera pixel clock.
//
// Ports:
//   clk    in  camera pixel clock (PCLK), inputs sampled on the rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of cam_rgb444_capture_if:
//            vsync, href, d          camera inputs
//            pix_data, pix_addr,     frame-buffer write port, one pix_we
//            pix_we                  pulse per pixel
//            frame_done              1-cycle pulse after a captured frame
//            line_err                sticky bad-line-length flag, cleared
//                                    at frame start
//
// Build option:
//   RGB565_IN_EN  when defined the camera delivers RGB565 and each channel is
//                 truncated to its top 4 bits; otherwise xRGB444 is expected
//                 and the upper nibble of the first byte is ignored.
// ---------------------------------------------------------------------------
module cam_rgb444_capture #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_W   = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cam_rgb444_capture_if.slave   bus
);

    if ((2 ** ADDR_W) < (H_ACTIVE * V_ACTIVE)) begin : g_addr_check
        $error("ADDR_W too small for H_ACTIVE*V_ACTIVE");
    end

    // col counts every completed pixel of the line, including dropped ones,
    // and saturates one past H_ACTIVE so a long line still reads as "not
    // equal to H_ACTIVE" at end of line without the counter wrapping.
    localparam int COL_W = $clog2(H_ACTIVE + 2);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);
    localparam logic [COL_W-1:0] COL_FULL = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0] COL_SAT  = COL_W'(H_ACTIVE + 1);
    localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(V_ACTIVE);

`ifdef RGB565_IN_EN
    // Only the bits that survive truncation are kept from the first byte:
    // R[4:1] and G[5:3].
    localparam int HI_W = 7;
`else
    // Only R[3:0] is meaningful in the first xRGB444 byte.
    localparam int HI_W = 4;
`endif

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        CAPTURE   = 1'b1
    } state_t;

    state_t             state_q;
    logic               vsync_q;
    logic               href_q;
    logic               phase_q;
    logic [HI_W-1:0]    hi_q;
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   row_q;
    logic [11:0]        pix_data_q;
    logic [ADDR_W-1:0]  pix_addr_q;
    logic               pix_we_q;
    logic               frame_done_q;
    logic               line_err_q;

    logic [HI_W-1:0]    hi_d;
    logic [11:0]        pix_data_d;
    logic               vsync_rise;
    logic               vsync_fall;
    logic               href_fall;
    logic               in_bounds;

`ifdef RGB565_IN_EN
    assign hi_d       = {bus.d[7:4], bus.d[2:0]};
    assign pix_data_d = {hi_q, bus.d[7], bus.d[4:1]};
`else
    assign hi_d       = bus.d[3:0];
    assign pix_data_d = {hi_q, bus.d};
`endif

    assign vsync_rise = bus.vsync & ~vsync_q;
    assign vsync_fall = ~bus.vsync & vsync_q;
    assign href_fall  = ~bus.href & href_q;
    assign in_bounds  = (col_q < COL_FULL) && (row_q < ROW_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_SYNC;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pix_data_q   <= '0;
            pix_addr_q   <= '0;
            pix_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            vsync_q      <= bus.vsync;
            href_q       <= bus.href;
            pix_we_q     <= 1'b0;
            frame_done_q <= 1'b0;

            // pix_addr holds the address of the pixel being written and
            // advances once that write has been presented. Because the
            // write strobe is already registered, a write pending when
            // vsync rises still completes.
            if (pix_we_q) begin
                pix_addr_q <= pix_addr_q + ADDR_W'(1);
            end

            case (state_q)
                WAIT_SYNC: begin
                    phase_q <= 1'b0;
                    if (vsync_fall) begin
                        state_q    <= CAPTURE;
                        pix_addr_q <= '0;
                        row_q      <= '0;
                        col_q      <= '0;
                        line_err_q <= 1'b0;
                    end
                end

                CAPTURE: begin
                    if (vsync_rise) begin
                        state_q      <= WAIT_SYNC;
                        frame_done_q <= 1'b1;
                        phase_q      <= 1'b0;
                    end else if (!bus.vsync) begin
                        if (bus.href) begin
                            if (!phase_q) begin
                                hi_q    <= hi_d;
                                phase_q <= 1'b1;
                            end else begin
                                phase_q <= 1'b0;
                                if (in_bounds) begin
                                    pix_we_q   <= 1'b1;
                                    pix_data_q <= pix_data_d;
                                end
                                if (col_q != COL_SAT) begin
                                    col_q <= col_q + COL_W'(1);
                                end
                            end
                        end else begin
                            // A dangling odd byte is simply forgotten here.
                            phase_q <= 1'b0;
                            if (href_fall) begin
                                if ((col_q != COL_FULL) && (row_q < ROW_END)) begin
                                    line_err_q <= 1'b1;
                                end
                                col_q <= '0;
                                if (row_q != ROW_END) begin
                                    row_q <= row_q + ROW_W'(1);
                                end
                            end
                        end
                    end
                end

                default: state_q <= WAIT_SYNC;
            endcase
        end
    end

    assign bus.pix_data   = pix_data_q;
    assign bus.pix_addr   = pix_addr_q;
    assign bus.pix_we     = pix_we_q;
    assign bus.frame_done = frame_done_q;
    assign bus.line_err   = line_err_q;

endmodule

// File: tb/tb_cam_rgb444_capture.sv
// ---------------------------------------------------------------------------
// tb_cam_rgb444_capture
//
// Drives camera frames with random byte data and line lengths into a small
// (16x6) instance of cam_rgb444_capture. A frame-level model predicts every
// frame-buffer write, the sticky line error and the end-of-frame pulse; a
// negedge process compares the DUT against it every cycle. A few literal
// pixel values pin the colour mapping.
// ---------------------------------------------------------------------------
module tb_cam_rgb444_capture;

    localparam int H  = 16;
    localparam int V  = 6;
    localparam int AW = 8;

`ifdef RGB565_IN_EN
    localparam logic [7:0]  P0A = 8'hF8, P0B = 8'h1F;
    localparam logic [11:0] P0X = 12'hF0F;
    localparam logic [7:0]  P1A = 8'h07, P1B = 8'hE0;
    localparam logic [11:0] P1X = 12'h0F0;
`else
    localparam logic [7:0]  P0A = 8'h03, P0B = 8'h47;
    localparam logic [11:0] P0X = 12'h347;
    localparam logic [7:0]  P1A = 8'h0A, P1B = 8'h5C;
    localparam logic [11:0] P1X = 12'hA5C;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cam_rgb444_capture_if #(.ADDR_W(AW)) bus_if ();

    cam_rgb444_capture #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .ADDR_W  (AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fd_cyc   = -1;

    // Frame model state
    bit m_cap  = 1'b0;
    int m_addr = 0;
    int m_row  = 0;
    int m_col  = 0;
    int m_err  = 0;
    int exp_addr[$];
    int exp_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Colour mapping from the camera byte pair, as channel arithmetic.
    function automatic int map_pix(input int b0, input int b1);
`ifdef RGB565_IN_EN
        int r5 = b0 >> 3;
        int g6 = ((b0 & 7) << 3) | (b1 >> 5);
        int b5 = b1 & 31;
        return ((r5 >> 1) << 8) | ((g6 >> 2) << 4) | (b5 >> 1);
`else
        return ((b0 & 15) << 8) | b1;
`endif
    endfunction

    function automatic void model_pixel(input int b0, input int b1);
        if (!m_cap) return;
        if (m_row < V && m_col < H) begin
            exp_addr.push_back(m_addr);
            exp_data.push_back(map_pix(b0, b1));
            m_addr++;
        end
        m_col++;
    endfunction

    function automatic void model_eol();
        if (!m_cap) return;
        if (m_row < V && m_col != H) m_err = 1;
        m_col = 0;
        if (m_row < V) m_row++;
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("frame_done", {31'd0, bus_if.frame_done}, {31'd0, (cyc == fd_cyc)});
        if (bus_if.pix_we !== 1'b0) begin
            if (exp_addr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got we=%b addr 0x%0h data 0x%0h, expected no write (cycle %0d)",
                         bus_if.pix_we, bus_if.pix_addr, bus_if.pix_data, cyc);
            end else begin
                chk("pix_addr", {24'd0, bus_if.pix_addr}, exp_addr.pop_front());
                chk("pix_data", {20'd0, bus_if.pix_data}, exp_data.pop_front());
            end
        end
    end

    task automatic drive_byte(input bit h, input logic [7:0] v);
        @(posedge clk);
        #1;
        bus_if.href = h;
        bus_if.d    = v;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_byte(1'b0, 8'h00);
    endtask

    // Sends one line of random bytes. A tight line keeps href high up to
    // the cycle where end_frame raises vsync.
    task automatic send_line(input int nbytes, input bit tight);
        int b0;
        int b;
        b0 = 0;
        for (int i = 0; i < nbytes; i++) begin
            b = int'($urandom_range(0, 255));
            drive_byte(1'b1, 8'(b));
            if (i % 2 == 1) model_pixel(b0, b);
            else            b0 = b;
        end
        if (!tight) begin
            drive_byte(1'b0, 8'h00);
            model_eol();
            idle(3);
            @(negedge clk);
            chk("line_err_after_line", {31'd0, bus_if.line_err}, m_err);
        end
    endtask

    task automatic start_frame();
        @(posedge clk);
        #1;
        bus_if.vsync = 1'b1;
        bus_if.href  = 1'b0;
        idle(2);
        @(posedge clk);
        #1;
        bus_if.vsync = 1'b0;
        m_cap  = 1'b1;
        m_addr = 0;
        m_row  = 0;
        m_col  = 0;
        m_err  = 0;
        idle(3);
        @(negedge clk);
        chk("frame_start_line_err", {31'd0, bus_if.line_err}, 0);
        chk("frame_start_addr", {24'd0, bus_if.pix_addr}, 0);
    endtask

    task automatic end_frame();
        @(posedge clk);
        #1;
        bus_if.vsync = 1'b1;
        bus_if.href  = 1'b0;
        if (m_cap) fd_cyc = cyc + 1;
        m_cap = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("writes_drained", exp_addr.size(), 0);
        chk("end_addr", {24'd0, bus_if.pix_addr}, m_addr);
        chk("end_line_err", {31'd0, bus_if.line_err}, m_err);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_pix_we"},     {31'd0, bus_if.pix_we}, 0);
        chk({tag, "_pix_data"},   {20'd0, bus_if.pix_data}, 0);
        chk({tag, "_pix_addr"},   {24'd0, bus_if.pix_addr}, 0);
        chk({tag, "_frame_done"}, {31'd0, bus_if.frame_done}, 0);
        chk({tag, "_line_err"},   {31'd0, bus_if.line_err}, 0);
    endtask

    function automatic int rand_len();
        case ($urandom_range(0, 3))
            0, 1:    return 2 * H;
            2:       return int'($urandom_range(1, 2 * H - 1));
            default: return int'($urandom_range(2 * H + 1, 2 * H + 24));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl;
        rst_n        = 1'b0;
        bus_if.vsync = 1'b0;
        bus_if.href  = 1'b0;
        bus_if.d     = 8'h00;

        // Reset held while the camera is mid-frame.
        for (int i = 0; i < 6; i++) drive_byte(1'b1, 8'($urandom_range(0, 255)));
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Remainder of the partial frame must be skipped.
        send_line(2 * H, 1'b0);
        send_line(2 * H + 6, 1'b0);
        end_frame();

        // Pinned pixels: latency, mapping, address 0 and 1, short line.
        start_frame();
        drive_byte(1'b1, P0A);
        drive_byte(1'b1, P0B);
        model_pixel(int'(P0A), int'(P0B));
        drive_byte(1'b1, P1A);
        @(negedge clk);
        chk("pin0_we",   {31'd0, bus_if.pix_we}, 1);
        chk("pin0_data", {20'd0, bus_if.pix_data}, {20'd0, P0X});
        chk("pin0_addr", {24'd0, bus_if.pix_addr}, 0);
        drive_byte(1'b1, P1B);
        model_pixel(int'(P1A), int'(P1B));
        drive_byte(1'b0, 8'h00);
        model_eol();
        @(negedge clk);
        chk("pin1_we",   {31'd0, bus_if.pix_we}, 1);
        chk("pin1_data", {20'd0, bus_if.pix_data}, {20'd0, P1X});
        chk("pin1_addr", {24'd0, bus_if.pix_addr}, 1);
        idle(3);
        @(negedge clk);
        chk("pin_line_err", {31'd0, bus_if.line_err}, 1);
        for (int l = 1; l < V; l++) send_line(2 * H, 1'b0);
        end_frame();

        // Nominal full frame.
        start_frame();
        for (int l = 0; l < V; l++) send_line(2 * H, 1'b0);
        end_frame();
        chk("nominal_addr", {24'd0, bus_if.pix_addr}, H * V);
        chk("nominal_err", {31'd0, bus_if.line_err}, 0);

        // Long line, short odd line, then overflow rows.
        start_frame();
        send_line(2 * H + 20, 1'b0);
        send_line(2 * (H - 4) + 1, 1'b0);
        for (int l = 2; l < V + 3; l++) send_line(2 * H, 1'b0);
        end_frame();
        chk("long_short_addr", {24'd0, bus_if.pix_addr}, H * V - 4);

        // Overflow with vsync rising right after the last pixel.
        start_frame();
        for (int l = 0; l < V + 3; l++) send_line(2 * H, 1'b0);
        send_line(2 * H, 1'b1);
        end_frame();
        chk("overflow_addr", {24'd0, bus_if.pix_addr}, H * V);

        // Tight end on an in-bounds row: pending write still issues.
        start_frame();
        for (int l = 0; l < V - 1; l++) send_line(2 * H, 1'b0);
        send_line(2 * H, 1'b1);
        end_frame();

        // Reset in the middle of a frame; rest of the frame is dropped.
        start_frame();
        send_line(2 * H, 1'b0);
        send_line(H, 1'b0);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        m_cap  = 1'b0;
        m_addr = 0;
        m_err  = 0;
        exp_addr.delete();
        exp_data.delete();
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_line(2 * H, 1'b0);
        send_line(H + 3, 1'b0);
        end_frame();

        // Randomised frames.
        for (int f = 0; f < 8; f++) begin
            start_frame();
            nl = int'($urandom_range(V - 1, V + 2));
            for (int l = 0; l < nl - 1; l++) send_line(rand_len(), 1'b0);
            send_line(rand_len(), 1'($urandom_range(0, 1)));
            end_frame();
        end

        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
